cp0_intc: RTL and testbench

- Parametrised successor to the fixed 6-line CP0 interrupt/timer logic.
- Holds Count, Compare, IntCtl and an implementation-specific edge-config/edge-clear pair.
- Synchronises N external interrupt lines, each individually level- or edge-triggered.
- Produces the masked interrupt request and the vectored-interrupt (VI) vector offset for the exception entry logic; sits beside the CP0 register file, which keeps Status/Cause/EPC.

---
 rtl/cp0_intc_pkg.sv | 18 +
 rtl/cp0_intc_if.sv | 11 +
 rtl/cp0_int_sync.sv | 41 ++++
 rtl/cp0_intc.sv | 144 ++++++++++++++
 tb/tb_cp0_intc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_intc_pkg.sv
// Shared CP0 interrupt/timer constants: register addresses {rd, sel}, IntCtl fields, vector bases.
package cp0_intc_pkg;

    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_INTCTL   = {5'd12, 3'd1};
    localparam logic [7:0] CP0_EDGECFG  = {5'd22, 3'd0};
    localparam logic [7:0] CP0_EDGEPEND = {5'd22, 3'd1};

    localparam int unsigned INTCTL_IPTI_HI = 31;
    localparam int unsigned INTCTL_IPTI_LO = 29;
    localparam int unsigned INTCTL_VS_HI   = 9;
    localparam int unsigned INTCTL_VS_LO   = 5;

    localparam logic [11:0] VEC_GENERAL = 12'h180;
    localparam logic [11:0] VEC_IRQ     = 12'h200;

endpackage

// File: rtl/cp0_intc_if.sv
// CP0 register access bus between the CP0 register file (master) and cp0_intc (slave).
interface cp0_intc_if;
    logic        mtc0;
    logic [31:0] mtc0_data;
    logic [7:0]  addr;
    logic [31:0] mfc0_data;
    logic        hit;

    modport master (output mtc0, mtc0_data, addr, input  mfc0_data, hit);
    modport slave  (input  mtc0, mtc0_data, addr, output mfc0_data, hit);
endinterface

// File: rtl/cp0_int_sync.sv
// Per-line input capture plus rising-edge detect. CP0_INTC_SYNC_EN selects a 2-flop
// synchroniser; otherwise a single sampling register is used for already-synchronous inputs.
module cp0_int_sync #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] int_in,
    output logic [W-1:0] s,
    output logic [W-1:0] rise_c
);
    logic [W-1:0] s_q;
    logic [W-1:0] prev_q;

`ifdef CP0_INTC_SYNC_EN
    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            s_q    <= '0;
        end else begin
            meta_q <= int_in;
            s_q    <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) s_q <= '0;
        else         s_q <= int_in;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prev_q <= '0;
        else         prev_q <= s_q;
    end

    assign s      = s_q;
    assign rise_c = s_q & ~prev_q;
endmodule

// File: rtl/cp0_intc.sv
// CP0 Count/Compare timer, IntCtl, edge/level external interrupts, priority and VI vector offset.
// Build option CP0_INTC_SYNC_EN adds a 2-flop synchroniser on int_in (3-cycle instead of 2-cycle latency).
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter int unsigned HW_INTS   = 6,
    parameter int unsigned COUNT_DIV = 2,
    parameter int unsigned TI_LINE   = 7
) (
    input  logic               clk,
    input  logic               resetn,
    cp0_intc_if.slave          bus,
    input  logic [HW_INTS-1:0] int_in,
    input  logic [7:0]         status_im,
    input  logic               status_ie,
    input  logic               status_exl,
    input  logic               status_erl,
    input  logic               cause_iv,
    input  logic [1:0]         ip_sw,
    output logic [7:0]         ip,
    output logic               timer_int,
    output logic               int_sig,
    output logic [2:0]         int_vec,
    output logic [11:0]        vec_off
);
    localparam int unsigned      PRE_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIV - 1);

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [31:0]        count_q, count_d, compare_q, compare_d;
    logic               timer_q, timer_d, block_q, block_d;
    logic [4:0]         vs_q, vs_d;
    logic [HW_INTS-1:0] cfg_q, cfg_d, pend_q, pend_d, clr_mask;
    logic [HW_INTS-1:0] sync_s, sync_rise;
    logic [7:0]         ip_q, ip_d, pend_c;
    logic [11:0]        vs_span;
    logic [31:0]        rd_data;
    logic               rd_hit;
    logic               wr_count, wr_compare, wr_intctl, wr_cfg, wr_pend;

    cp0_int_sync #(.W(HW_INTS)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .int_in (int_in),
        .s      (sync_s),
        .rise_c (sync_rise)
    );

    assign wr_count   = bus.mtc0 && (bus.addr == CP0_COUNT);
    assign wr_compare = bus.mtc0 && (bus.addr == CP0_COMPARE);
    assign wr_intctl  = bus.mtc0 && (bus.addr == CP0_INTCTL);
    assign wr_cfg     = bus.mtc0 && (bus.addr == CP0_EDGECFG);
    assign wr_pend    = bus.mtc0 && (bus.addr == CP0_EDGEPEND);
    assign clr_mask   = wr_pend ? bus.mtc0_data[HW_INTS-1:0] : '0;

    // Next state; a Count write beats an increment, a Compare write beats a match.
    always_comb begin
        pre_d     = (pre_q == PRE_LAST) ? '0 : PRE_W'(pre_q + PRE_W'(1));
        count_d   = count_q + 32'(pre_q == PRE_LAST);
        compare_d = compare_q;
        vs_d      = vs_q;
        cfg_d     = cfg_q;
        timer_d   = timer_q;
        block_d   = block_q;
        if (wr_count) begin
            count_d = bus.mtc0_data;
            pre_d   = '0;
        end
        if (wr_compare)   compare_d = bus.mtc0_data;
        if (wr_intctl)    vs_d      = bus.mtc0_data[INTCTL_VS_HI:INTCTL_VS_LO];
        if (wr_cfg)       cfg_d     = bus.mtc0_data[HW_INTS-1:0];
        // block_q stops a freshly cleared timer re-raising until Count moves off the match value
        if (wr_compare)                                  timer_d = 1'b0;
        else if ((count_q == compare_q) && !block_q)     timer_d = 1'b1;
        if (wr_compare)                                  block_d = 1'b1;
        else if (count_d != count_q)                     block_d = 1'b0;
        pend_d = (pend_q & ~clr_mask) | (sync_rise & cfg_q);
        ip_d      = '0;
        ip_d[1:0] = ip_sw;
        for (int i = 0; i < int'(HW_INTS); i++) begin
            ip_d[i+2] = cfg_q[i] ? pend_d[i] : sync_s[i];
        end
        ip_d[TI_LINE] = ip_d[TI_LINE] | timer_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
            block_q   <= 1'b0;
            vs_q      <= '0;
            cfg_q     <= '0;
            pend_q    <= '0;
            ip_q      <= '0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            timer_q   <= timer_d;
            block_q   <= block_d;
            vs_q      <= vs_d;
            cfg_q     <= cfg_d;
            pend_q    <= pend_d;
            ip_q      <= ip_d;
        end
    end

    // Masked request, priority encode (IP7 highest) and VI offset.
    always_comb begin
        pend_c  = ip_q & status_im;
        int_sig = (|pend_c) && status_ie && !status_exl && !status_erl;
        int_vec = '0;
        for (int i = 0; i < 8; i++) begin
            if (pend_c[i]) int_vec = 3'(i);
        end
        vs_span = 12'({vs_q, 5'b0});
        if (!cause_iv)        vec_off = VEC_GENERAL;
        else if (vs_q == '0)  vec_off = VEC_IRQ;
        else                  vec_off = VEC_IRQ + 12'(int_vec) * vs_span;
    end

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b1;
        case (bus.addr)
            CP0_COUNT:    rd_data = count_q;
            CP0_COMPARE:  rd_data = compare_q;
            CP0_INTCTL: begin
                rd_data[INTCTL_IPTI_HI:INTCTL_IPTI_LO] = 3'(TI_LINE);
                rd_data[INTCTL_VS_HI:INTCTL_VS_LO]     = vs_q;
            end
            CP0_EDGECFG:  rd_data = 32'(cfg_q);
            CP0_EDGEPEND: rd_data = 32'(pend_q);
            default:      rd_hit  = 1'b0;
        endcase
    end

    assign bus.mfc0_data = rd_data;
    assign bus.hit       = rd_hit;
    assign ip            = ip_q;
    assign timer_int     = timer_q;
endmodule

// File: tb/tb_cp0_intc.sv
// Randomised bench for cp0_intc against a rule-level reference model; directed cases first.
module tb_cp0_intc;
    import cp0_intc_pkg::*;

    localparam int unsigned HW_INTS   = 6;
    localparam int unsigned COUNT_DIV = 2;
    localparam int unsigned TI_LINE   = 7;
`ifdef CP0_INTC_SYNC_EN
    localparam int unsigned SYNC_DEPTH = 2;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif
    localparam int unsigned LAT = SYNC_DEPTH + 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic [HW_INTS-1:0] int_in;
    logic [7:0]         status_im;
    logic               status_ie, status_exl, status_erl, cause_iv;
    logic [1:0]         ip_sw;
    logic [7:0]         ip;
    logic               timer_int, int_sig;
    logic [2:0]         int_vec;
    logic [11:0]        vec_off;

    always #5 clk = ~clk;

    cp0_intc_if bus ();

    cp0_intc #(.HW_INTS(HW_INTS), .COUNT_DIV(COUNT_DIV), .TI_LINE(TI_LINE)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .int_in     (int_in),
        .status_im  (status_im),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_erl (status_erl),
        .cause_iv   (cause_iv),
        .ip_sw      (ip_sw),
        .ip         (ip),
        .timer_int  (timer_int),
        .int_sig    (int_sig),
        .int_vec    (int_vec),
        .vec_off    (vec_off)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: Count is base + elapsed/COUNT_DIV; input history stands in for the synchroniser.
    logic [31:0]        m_base, m_cmp;
    int unsigned        m_since;
    bit                 m_tmr, m_blk, seen;
    logic [4:0]         m_vs;
    logic [HW_INTS-1:0] m_cfg, m_pend;
    logic [7:0]         m_ip;
    logic [HW_INTS-1:0] hist[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_since / COUNT_DIV);
    endfunction

    // Synchroniser output as it stood 'back' edges before the latest sample.
    function automatic logic [HW_INTS-1:0] sync_at(input int unsigned back);
        if (hist.size() <= back) return '0;
        return hist[hist.size() - 1 - back];
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            CP0_COUNT:    return m_count();
            CP0_COMPARE:  return m_cmp;
            CP0_INTCTL:   return (32'(TI_LINE) << 29) | (32'(m_vs) << 5);
            CP0_EDGECFG:  return 32'(m_cfg);
            CP0_EDGEPEND: return 32'(m_pend);
            default:      return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_base = '0; m_cmp = '0; m_since = 0; m_tmr = 0; m_blk = 0;
        m_vs = '0; m_cfg = '0; m_pend = '0; m_ip = '0;
        hist.delete();
    endtask

    task automatic model_step();
        logic [31:0]        cnt_pre, cnt_post;
        logic [HW_INTS-1:0] s_cur, s_prev, clr;
        bit                 wr;
        wr      = bus.mtc0;
        cnt_pre = m_count();
        s_cur   = sync_at(SYNC_DEPTH - 1);
        s_prev  = sync_at(SYNC_DEPTH);
        clr     = (wr && bus.addr == CP0_EDGEPEND) ? bus.mtc0_data[HW_INTS-1:0] : '0;
        m_pend  = (m_pend & ~clr) | (s_cur & ~s_prev & m_cfg);
        if (wr && bus.addr == CP0_COMPARE)        m_tmr = 0;
        else if (cnt_pre == m_cmp && !m_blk)      m_tmr = 1;
        if (wr && bus.addr == CP0_COUNT) begin
            m_base  = bus.mtc0_data;
            m_since = 0;
        end else begin
            m_since++;
        end
        cnt_post = m_count();
        if (wr && bus.addr == CP0_COMPARE)        m_blk = 1;
        else if (cnt_post != cnt_pre)             m_blk = 0;
        m_ip      = '0;
        m_ip[1:0] = ip_sw;
        for (int i = 0; i < int'(HW_INTS); i++) m_ip[i+2] = m_cfg[i] ? m_pend[i] : s_cur[i];
        m_ip[TI_LINE] = m_ip[TI_LINE] | m_tmr;
        if (wr && bus.addr == CP0_COMPARE) m_cmp = bus.mtc0_data;
        if (wr && bus.addr == CP0_INTCTL)  m_vs  = bus.mtc0_data[9:5];
        if (wr && bus.addr == CP0_EDGECFG) m_cfg = bus.mtc0_data[HW_INTS-1:0];
        hist.push_back(int_in);
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic compare_all();
        logic [7:0] pend;
        int         exp_vec;
        bit         exp_hit;
        pend    = m_ip & status_im;
        exp_vec = (pend == 0) ? 0 : $clog2(int'(pend) + 1) - 1;
        exp_hit = bus.addr inside {CP0_COUNT, CP0_COMPARE, CP0_INTCTL, CP0_EDGECFG, CP0_EDGEPEND};
        check_eq("ip",        32'(ip),        32'(m_ip));
        check_eq("timer_int", 32'(timer_int), 32'(m_tmr));
        check_eq("int_sig",   32'(int_sig),
                 32'((pend != 0) && status_ie && !status_exl && !status_erl));
        check_eq("int_vec",   32'(int_vec),   32'(exp_vec));
        check_eq("vec_off",   32'(vec_off),
                 !cause_iv ? 32'h180 : (32'h200 + 32'(exp_vec) * 32'(m_vs) * 32) % 4096);
        check_eq("hit",       32'(bus.hit),   32'(exp_hit));
        check_eq("mfc0_data", bus.mfc0_data,  m_read(bus.addr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else         model_step();
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.mtc0 = 1'b1; bus.addr = a; bus.mtc0_data = d;
        tick();
        bus.mtc0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; int_in = '0; status_im = '0; status_ie = 0; status_exl = 0;
        status_erl = 0; cause_iv = 0; ip_sw = '0;
        bus.mtc0 = 0; bus.addr = CP0_INTCTL; bus.mtc0_data = '0;
        model_reset();
        #1;
        compare_all();
        tick(); tick();
        resetn = 1'b1;
        check_eq("rst_intctl", bus.mfc0_data, 32'hE000_0000);
        check_eq("rst_vecoff", 32'(vec_off),  32'h180);

        // Count load and 32-bit wrap
        wr(CP0_COUNT, 32'hFFFF_FFFE);
        bus.addr = CP0_COUNT;
        tick(); tick();
        check_eq("count_ff", bus.mfc0_data, 32'hFFFF_FFFF);
        tick(); tick();
        check_eq("count_wrap", bus.mfc0_data, 32'h0);

        // Timer match, clear on Compare write, no re-raise while still equal
        wr(CP0_COMPARE, 32'h10);
        wr(CP0_COUNT, 32'hC);
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (timer_int) seen = 1;
        end
        check_eq("timer_set", 32'(seen), 32'd1);
        tick();
        wr(CP0_COUNT, 32'h40);
        wr(CP0_COMPARE, 32'h40);
        check_eq("timer_clr", 32'(timer_int), 32'd0);
        tick(); tick();
        check_eq("timer_noreraise", 32'(timer_int), 32'd0);

        // Level line 0
        status_im = 8'h04; status_ie = 1;
        int_in[0] = 1'b1;
        repeat (LAT - 1) tick();
        check_eq("lvl_early", 32'(int_sig), 32'd0);
        tick();
        check_eq("lvl_on", 32'(int_sig), 32'd1);
        int_in[0] = 1'b0;
        repeat (LAT) tick();
        check_eq("lvl_off", 32'(int_sig), 32'd0);

        // Edge line 1: sticky, W1C, set beats same-cycle clear
        wr(CP0_EDGECFG, 32'h2);
        status_im = 8'h08;
        int_in[1] = 1'b1; tick(); int_in[1] = 1'b0;
        repeat (LAT + 1) tick();
        check_eq("edge_sticky", 32'(ip[3]), 32'd1);
        wr(CP0_EDGEPEND, 32'h2);
        check_eq("edge_w1c", 32'(ip[3]), 32'd0);
        int_in[1] = 1'b1; tick(); int_in[1] = 1'b0;
        repeat (SYNC_DEPTH - 1) tick();
        wr(CP0_EDGEPEND, 32'h2);
        check_eq("edge_set_wins", 32'(ip[3]), 32'd1);
        wr(CP0_EDGEPEND, 32'h3F);
        wr(CP0_EDGECFG, 32'h0);

        // VI priority and offset, then EXL masking
        status_im = 8'hFF; cause_iv = 1;
        wr(CP0_INTCTL, 32'h2 << 5);
        int_in = 6'b001001;
        repeat (LAT) tick();
        check_eq("vi_vec", 32'(int_vec), 32'd5);
        check_eq("vi_off", 32'(vec_off), 32'h340);
        status_exl = 1;
        tick();
        check_eq("exl_sig", 32'(int_sig), 32'd0);
        check_eq("exl_vec", 32'(int_vec), 32'd5);
        status_exl = 0;

        // Random traffic, with one asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            logic [7:0] owned[5];
            owned = '{CP0_COUNT, CP0_COMPARE, CP0_INTCTL, CP0_EDGECFG, CP0_EDGEPEND};
            if ($urandom_range(0, 3) == 0) int_in = HW_INTS'($urandom);
            ip_sw      = 2'($urandom);
            status_im  = 8'($urandom);
            status_ie  = 1'($urandom);
            status_exl = ($urandom_range(0, 5) == 0);
            status_erl = ($urandom_range(0, 7) == 0);
            cause_iv   = 1'($urandom);
            bus.addr   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : owned[$urandom_range(0, 4)];
            bus.mtc0   = ($urandom_range(0, 5) == 0);
            bus.mtc0_data = $urandom;
            if (bus.addr == CP0_COMPARE && $urandom_range(0, 1) == 1)
                bus.mtc0_data = m_count() + 32'($urandom_range(0, 6));
            if (n == 200) begin
                #2;
                resetn = 1'b0;
                #1;
                model_reset();
                compare_all();
                tick();
                resetn = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
